register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32 x 32-bit RISC-V integer register file for the core's decode stage.
- Two combinational read ports and one synchronous write port; x0 is hardwired to zero.
- After reset, or on a clear request, an internal sweep FSM zeroes x1..x31 one register per cycle, so the array can map to distributed RAM without a per-bit reset.
- Its read ports are the signals the team's register-file x0 assertions check.

Parameters:
- DATA_WIDTH, 32, register width in bits
- NUM_REGS, 32, register count; must be a power of two, at least 2
- ADDR_WIDTH, $clog2(NUM_REGS), register index width

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous request to re-run the zeroing sweep
- wr_en  input  1  write enable
- wr_reg  input  ADDR_WIDTH  write register index
- wr_data  input  DATA_WIDTH  write data
- rd_reg_1  input  ADDR_WIDTH  read port 1 index
- rd_data_1  output  DATA_WIDTH  read port 1 data, combinational
- rd_reg_2  input  ADDR_WIDTH  read port 2 index
- rd_data_2  output  DATA_WIDTH  read port 2 data, combinational
- ready  output  1  high when the sweep is done and writes are accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=INIT, sweep_idx=1, ready=0. rd_data_1 and rd_data_2 read 0 throughout reset.
- FSM states:
  - INIT: each cycle writes 0 to regs[sweep_idx], then increments sweep_idx. When the cycle with sweep_idx==NUM_REGS-1 completes, go to RUN. INIT lasts exactly NUM_REGS-1 cycles (31 by default).
  - RUN: ready=1.
    - A write occurs when wr_en=1 and wr_reg!=0: regs[wr_reg] <= wr_data at the edge.
    - Writes to x0 are silently dropped.
    - clr=1 in RUN: go to INIT and set sweep_idx=1. Any write in that same cycle is dropped.
- During INIT:
  - ready=0.
  - wr_en is ignored.
  - Both read ports return 0, regardless of array contents.
  - clr is ignored, because the sweep is already running.
- Reads:
  - rd_data_N = 0 when rd_reg_N==0, or when state is INIT.
  - Otherwise rd_data_N = regs[rd_reg_N], zero read latency.
  - Both ports may address the same register, returning identical data.
- Same-cycle read and write of the same nonzero register: see Optional Feature.
- rst asserted mid-sweep or mid-RUN: immediately return to the reset state and restart the full sweep after deassertion.
- The sweep index is ADDR_WIDTH+1 bits wide, to avoid wrap at NUM_REGS-1. It never addresses x0.
- Simultaneous clr and rst: rst wins.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in RUN, if wr_en=1, wr_reg!=0 and rd_reg_N==wr_reg, then rd_data_N = wr_data in the same cycle (write-first forwarding). x0 is never bypassed.
- Undefined: rd_data_N returns the pre-write array value (read-first). The new value is visible from the cycle after the edge.

Test Plan:
1. Reset and sweep: assert rst, write pattern 0xDEADBEEF to all registers before reset, release rst. ready stays 0 for exactly 31 cycles, then rises. Reads of x1..x31 all return 0.
2. Basic write/read: in RUN, write x5=0x12345678. Next cycle rd_reg_1=5 and rd_reg_2=5 both return 0x12345678; rd_reg_1=0 returns 0.
3. x0 protection: write wr_reg=0, wr_data=0xFFFFFFFF. On every following cycle, rd_data_1 and rd_data_2 with index 0 return 0.
4. Same-cycle hazard: x7=0xAAAA0000, then in one cycle write x7=0x5555 while rd_reg_1=7.
   - Bypass defined: rd_data_1 reads 0x5555 that cycle.
   - Bypass undefined: reads 0xAAAA0000 that cycle, 0x5555 the next.
5. Clear mid-operation: x3=0x1 and x31=0x2, then pulse clr together with a write to x9=0x9.
   - ready drops for 31 cycles and reads return 0 during the sweep.
   - wr_en pulses during the sweep have no effect.
   - After the sweep, x3=x9=x31=0.
6. Reset mid-sweep: assert rst at sweep cycle 10, release it. ready rises exactly 31 cycles after release.

Source files
------------

// File: rtl/register_file.sv
// 32 x 32 RISC-V integer register file: two combinational read ports, one write port, x0 fixed at zero.
// A sweep FSM zeroes x1..x(N-1) after reset or clr; define REGFILE_WRITE_BYPASS_EN for write-first reads.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_reg,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_reg_1,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic [ADDR_WIDTH-1:0] rd_reg_2,
  output logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  ready
);

  localparam int unsigned IDX_WIDTH = ADDR_WIDTH + 1;
  localparam logic [IDX_WIDTH-1:0] FIRST_IDX = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  sweep_idx;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  wr_fire;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_data;

  // A clear request takes priority over a user write in the same cycle.
  assign wr_fire = (state == RUN) && wr_en && (wr_reg != '0) && !clr;

  // Single array write port shared by the sweep and user writes.
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = '0;
    arr_data = '0;
    if (state == INIT) begin
      arr_we   = 1'b1;
      arr_addr = sweep_idx[ADDR_WIDTH-1:0];
    end else if (wr_fire) begin
      arr_we   = 1'b1;
      arr_addr = wr_reg;
      arr_data = wr_data;
    end
  end

  // No reset on the array so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (arr_we && !rst) begin
      regs[arr_addr] <= arr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweep_idx <= FIRST_IDX;
      ready     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_idx <= sweep_idx + IDX_WIDTH'(1);
          if (sweep_idx == LAST_IDX) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (clr) begin
            state     <= INIT;
            sweep_idx <= FIRST_IDX;
            ready     <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          sweep_idx <= FIRST_IDX;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if ((state == RUN) && (idx != '0)) begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (wr_en && (wr_reg == idx)) begin
        val = wr_data;
      end else begin
        val = regs[idx];
      end
`else
      val = regs[idx];
`endif
    end
    return val;
  endfunction

  always_comb begin
    rd_data_1 = read_port(rd_reg_1);
    rd_data_2 = read_port(rd_reg_2);
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus hand-written sweep/reset/clear sequences.
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          wr_en;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_reg_1;
  logic [AW-1:0] rd_reg_2;
  logic [DW-1:0] rd_data_1;
  logic [DW-1:0] rd_data_2;
  logic          ready;

  int n_vec = 0;
  int n_err = 0;

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg_1  (rd_reg_1),
    .rd_data_1 (rd_data_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_2 (rd_data_2),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // port 0 = ready, 1 = rd_data_1, 2 = rd_data_2
  typedef struct {
    string         name;
    int            port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd1;
    logic [AW-1:0] rd2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t vecs[10];

  task automatic push(input string name, input int port, input logic [DW-1:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t          e;
    logic [DW-1:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.port)
        1:       act = rd_data_1;
        2:       act = rd_data_2;
        default: act = {{(DW-1){1'b0}}, ready};
      endcase
      n_vec++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    wr_en    = we;
    wr_reg   = wr;
    wr_data  = wd;
    rd_reg_1 = r1;
    rd_reg_2 = r2;
  endtask

  // Runs the sweep with wr_en hammering x9; reads must be 0 and ready low until it ends.
  // stop_at >= 0 returns early after that many cycles; otherwise the length is checked.
  task automatic sweep(input string name, input int clr_at, input int stop_at);
    int cnt;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100 && cnt != stop_at) begin
      drive(1'b1, 5'd9, 32'hFFFF_FFFF, 5'd31, 5'd9);
      clr = (cnt == clr_at);
      push({name, " sweep rd1"}, 1, '0);
      push({name, " sweep rd2"}, 2, '0);
      push({name, " sweep ready"}, 0, '0);
      cycle();
      cnt++;
    end
    wr_en = 1'b0;
    clr   = 1'b0;
    if (stop_at < 0) begin
      n_vec++;
      if (cnt != 31) begin
        n_err++;
        $display("FAIL %s sweep length: got %0d cycles, expected 31", name, cnt);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, '0, '0, AW'(i), AW'(32 - i));
      push({name, " zero rd1"}, 1, '0);
      push({name, " zero rd2"}, 2, '0);
      cycle();
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    drive(v.wr_en, v.wr_reg, v.wr_data, v.rd1, v.rd2);
    push({name, " rd1"}, 1, v.exp1);
    push({name, " rd2"}, 2, v.exp2);
    push({name, " ready"}, 0, 32'd1);
    cycle();
  endtask

  initial begin
    logic [DW-1:0] haz_exp;
`ifdef REGFILE_WRITE_BYPASS_EN
    haz_exp = 32'h0000_5555;
`else
    haz_exp = 32'hAAAA_0000;
`endif

    //          we    wr     wdata          rd1    rd2    exp1           exp2
    vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd0,  5'd0,  32'h0,         32'h0};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,         32'h0};
    vecs[3] = '{1'b1, 5'd10, 32'hA5A5_A5A5, 5'd0,  5'd5,  32'h0,         32'h1234_5678};
    vecs[4] = '{1'b1, 5'd31, 32'h0000_0002, 5'd10, 5'd1,  32'hA5A5_A5A5, 32'h0};
    vecs[5] = '{1'b1, 5'd3,  32'h0000_0001, 5'd31, 5'd10, 32'h0000_0002, 32'hA5A5_A5A5};
    vecs[6] = '{1'b0, 5'd3,  32'h0000_FFFF, 5'd3,  5'd0,  32'h0000_0001, 32'h0};
    vecs[7] = '{1'b1, 5'd1,  32'hCAFE_F00D, 5'd3,  5'd31, 32'h0000_0001, 32'h0000_0002};
    vecs[8] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd1,  5'd1,  32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[9] = '{1'b1, 5'd7,  32'hAAAA_0000, 5'd0,  5'd0,  32'h0,         32'h0};

    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, '0, '0, 5'd5, 5'd0);
    @(posedge clk);
    #1;
    push("reset rd1", 1, '0);
    push("reset rd2", 2, '0);
    push("reset ready", 0, '0);
    cycle();
    rst = 1'b0;
    sweep("power-up", -1, -1);

    // Test 1: fill with a pattern, then reset and confirm the sweep clears it.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, AW'(i), 32'hDEAD_BEEF, 5'd0, 5'd0);
      cycle();
    end
    drive(1'b0, '0, '0, 5'd17, 5'd31);
    push("pattern rd1", 1, 32'hDEAD_BEEF);
    push("pattern rd2", 2, 32'hDEAD_BEEF);
    cycle();
    rst = 1'b1;
    push("rst held rd1", 1, '0);
    push("rst held ready", 0, '0);
    cycle();
    rst = 1'b0;
    sweep("t1", 3, -1);
    check_all_zero("t1");

    // Tests 2/3: table of writes and reads, including x0 writes.
    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Test 4: same-cycle write and read of x7.
    drive(1'b1, 5'd7, 32'h0000_5555, 5'd7, 5'd0);
    push("hazard same cycle", 1, haz_exp);
    push("hazard x0", 2, '0);
    cycle();
    drive(1'b0, '0, '0, 5'd7, 5'd7);
    push("hazard next rd1", 1, 32'h0000_5555);
    push("hazard next rd2", 2, 32'h0000_5555);
    cycle();

    // Test 5: clr with a simultaneous write to x9; clr mid-sweep is ignored.
    drive(1'b1, 5'd9, 32'h0000_0009, 5'd3, 5'd31);
    clr = 1'b1;
    push("clr cycle rd1", 1, 32'h0000_0001);
    push("clr cycle rd2", 2, 32'h0000_0002);
    push("clr cycle ready", 0, 32'd1);
    cycle();
    clr = 1'b0;
    sweep("t5", 5, -1);
    drive(1'b0, '0, '0, 5'd3, 5'd9);
    push("post clr x3", 1, '0);
    push("post clr x9", 2, '0);
    cycle();
    drive(1'b0, '0, '0, 5'd31, 5'd7);
    push("post clr x31", 1, '0);
    push("post clr x7", 2, '0);
    cycle();

    // Test 6: reset (with clr) ten cycles into a sweep restarts it in full.
    drive(1'b1, 5'd4, 32'h0000_0044, 5'd0, 5'd0);
    cycle();
    clr = 1'b1;
    wr_en = 1'b0;
    cycle();
    clr = 1'b0;
    sweep("t6 pre", -1, 10);
    rst = 1'b1;
    clr = 1'b1;
    drive(1'b0, '0, '0, 5'd4, 5'd4);
    push("t6 rst rd1", 1, '0);
    push("t6 rst ready", 0, '0);
    cycle();
    cycle();
    rst = 1'b0;
    clr = 1'b0;
    sweep("t6", -1, -1);
    drive(1'b1, 5'd12, 32'h0BAD_CAFE, 5'd4, 5'd0);
    push("t6 post x4", 1, '0);
    cycle();
    drive(1'b0, '0, '0, 5'd12, 5'd12);
    push("t6 post x12 rd1", 1, 32'h0BAD_CAFE);
    push("t6 post x12 rd2", 2, 32'h0BAD_CAFE);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
